// File: rtl/shift_unit_seq_if.sv
// Handshake/operand bundle between the control FSM (master) and the shift unit (slave).
interface shift_unit_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        Shift;
  logic [5:0]        Num;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;

  modport master (
    output start, Shift, Num, data_in,
    input  result, busy, done
  );

  modport slave (
    input  start, Shift, Num, data_in,
    output result, busy, done
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential shifter: pass/SLL/SRL/SRA, one bit per clock with start/busy/done handshake.
// Define SHIFT_UNIT_BARREL_EN to replace the iterative loop with a single-cycle barrel shift.
module shift_unit_seq #(
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  shift_unit_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            stateReg;
  logic [DATA_W-1:0] resultReg;
  logic              busyReg;
  logic              doneReg;

  // Effective amount: pass forces 0, otherwise Num clamped to DATA_W.
  logic [6:0] numWide;
  logic [6:0] kWide;
  always_comb begin
    numWide = {1'b0, bus.Num};
    if (bus.Shift == 2'b00)
      kWide = 7'd0;
    else if (numWide >= 7'(DATA_W))
      kWide = 7'(DATA_W);
    else
      kWide = numWide;
  end

`ifdef SHIFT_UNIT_BARREL_EN
  logic [DATA_W-1:0] barrelOut;
  always_comb begin
    case (bus.Shift)
      2'b01:   barrelOut = bus.data_in << kWide;
      2'b10:   barrelOut = bus.data_in >> kWide;
      2'b11:   barrelOut = DATA_W'($signed(bus.data_in) >>> kWide);
      default: barrelOut = bus.data_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      resultReg <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            resultReg <= barrelOut;
            stateReg  <= DONE;
            busyReg   <= 1'b1;
            doneReg   <= 1'b1;
          end
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end
`else
  localparam int CW = $clog2(DATA_W) + 1;

  logic [CW-1:0]     countReg;
  logic [1:0]        opReg;
  logic [DATA_W-1:0] stepOut;

  always_comb begin
    case (opReg)
      2'b01:   stepOut = {resultReg[DATA_W-2:0], 1'b0};
      2'b10:   stepOut = {1'b0, resultReg[DATA_W-1:1]};
      2'b11:   stepOut = {resultReg[DATA_W-1], resultReg[DATA_W-1:1]};
      default: stepOut = resultReg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      resultReg <= '0;
      countReg  <= '0;
      opReg     <= 2'b00;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            resultReg <= bus.data_in;
            opReg     <= bus.Shift;
            countReg  <= kWide[CW-1:0];
            busyReg   <= 1'b1;
            // kWide is zero for pass, so a nonzero amount implies a real shift
            if (kWide != 7'd0) begin
              stateReg <= SHIFT;
              doneReg  <= 1'b0;
            end else begin
              stateReg <= DONE;
              doneReg  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          resultReg <= stepOut;
          countReg  <= countReg - 1'b1;
          if (countReg == CW'(1)) begin
            stateReg <= DONE;
            doneReg  <= 1'b1;
          end
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign bus.result = resultReg;
  assign bus.busy   = busyReg;
  assign bus.done   = doneReg;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: stimulus pushes expected result/latency, a monitor checks on done.
module tb_shift_unit_seq;
  logic clk;
  logic rst;

  shift_unit_seq_if #(.DATA_W(32)) bus ();

  shift_unit_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          startEdge;
    int          lat;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   edgeCnt  = 0;
  int   busyCnt  = 0;

  always @(posedge clk) edgeCnt++;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!bus.busy) busyCnt = 0;
    else           busyCnt++;
    if (bus.done) begin
      if (expQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_done: done=1 with no operation outstanding, result=%08h", bus.result);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (bus.result !== e.res) begin
          failures++;
          $display("FAIL %s_result: got %08h expected %08h", e.name, bus.result, e.res);
        end else
          $display("op %s result=%08h ok", e.name, bus.result);
        checks++;
        if (edgeCnt - e.startEdge + 1 != e.lat) begin
          failures++;
          $display("FAIL %s_latency: got %0d edges expected %0d", e.name, edgeCnt - e.startEdge + 1, e.lat);
        end
        checks++;
        if (busyCnt != e.lat) begin
          failures++;
          $display("FAIL %s_busy_cycles: got %0d expected %0d", e.name, busyCnt, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else
      $display("check %s = %08h ok", name, act);
  endtask

  function automatic int expLatency(input logic [1:0] op, input int num);
`ifdef SHIFT_UNIT_BARREL_EN
    return 1;
`else
    if (op == 2'b00) return 1;
    return ((num > 32) ? 32 : num) + 1;
`endif
  endfunction

  // Launch one op once the unit is idle; extra start pulses (ignored) follow for holdStart cycles.
  task automatic runOp(input string name, input logic [1:0] op, input int num,
                       input logic [31:0] data, input logic [31:0] exp, input int holdStart);
    exp_t e;
    int   n;
    n = 0;
    while (bus.busy && n < 100) begin tick(); n++; end
    if (bus.busy) begin
      checks++; failures++;
      $display("FAIL %s_idle_wait: busy=%b expected 0", name, bus.busy);
    end
    bus.start   = 1'b1;
    bus.Shift   = op;
    bus.Num     = 6'(num);
    bus.data_in = data;
    e.res = exp; e.startEdge = edgeCnt + 1; e.lat = expLatency(op, num); e.name = name;
    expQ.push_back(e);
    tick();
    // scramble operands after the start edge; they must not affect the operation
    bus.Shift   = ~op;
    bus.Num     = 6'(num + 3);
    bus.data_in = ~data;
    if (holdStart > 0) begin
      bus.Num     = 6'd10;
      bus.data_in = 32'd5;
      repeat (holdStart) tick();
    end
    bus.start = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin tick(); n++; end
    if (expQ.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_done_timeout: no done within 100 cycles, expected result %08h", name, exp);
      expQ.delete();
    end
  endtask

  initial begin
    int holdN;
`ifdef SHIFT_UNIT_BARREL_EN
    holdN = 1;
`else
    holdN = 3;
`endif
    rst = 1'b1;
    bus.start = 1'b0; bus.Shift = 2'b00; bus.Num = 6'd0; bus.data_in = 32'd0;
    tick(); tick();
    check("reset_result", bus.result, 32'h0);
    check("reset_busy",   {31'd0, bus.busy}, 32'h0);
    check("reset_done",   {31'd0, bus.done}, 32'h0);
    rst = 1'b0;
    tick();

    // reset in the middle of a long SLL
    begin
      exp_t e;
      bus.start = 1'b1; bus.Shift = 2'b01; bus.Num = 6'd20; bus.data_in = 32'h0000_0001;
      e.res = 32'h0010_0000; e.startEdge = edgeCnt + 1; e.lat = expLatency(2'b01, 20); e.name = "aborted";
      expQ.push_back(e);
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("midop_rst_result", bus.result, 32'h0);
      check("midop_rst_busy",   {31'd0, bus.busy}, 32'h0);
      check("midop_rst_done",   {31'd0, bus.done}, 32'h0);
      expQ.delete();
      tick();
      rst = 1'b0;
      repeat (30) tick();
    end

    runOp("sll4",       2'b01, 4,  32'h0000_0001, 32'h0000_0010, 0);
    runOp("srl4",       2'b10, 4,  32'h8000_00F0, 32'h0800_000F, 0);
    runOp("sra4",       2'b11, 4,  32'h8000_00F0, 32'hF800_000F, 0);
    runOp("pass17",     2'b00, 17, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    runOp("sll0",       2'b01, 0,  32'h1234_5678, 32'h1234_5678, 0);
    runOp("sll40",      2'b01, 40, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    runOp("sra40",      2'b11, 40, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runOp("srl40",      2'b10, 40, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    runOp("srl31",      2'b10, 31, 32'h8000_0000, 32'h0000_0001, 0);
    runOp("sra_pos",    2'b11, 8,  32'h7F00_0000, 32'h007F_0000, 0);
    runOp("sll_busy",   2'b01, 3,  32'h0000_0001, 32'h0000_0008, holdN);
    runOp("b2b_sra1",   2'b11, 1,  32'h8000_0000, 32'hC000_0000, 0);

    repeat (4) tick();
    check("idle_hold_result", bus.result, 32'hC000_0000);
    check("idle_busy",        {31'd0, bus.busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
